cp0: RTL and testbench
======================

Name: cp0

Overview:
- Coprocessor-0 register block in the M stage of the 5-stage MIPS pipeline.
- Consumes the exception flag and code produced by the E-stage exception checker (piped through E/M), the M-stage PC and delay-slot flag, and 6 hardware interrupt lines.
- Holds SR/Cause/EPC/PRId, arbitrates interrupt versus exception, and raises the single-cycle flush/redirect request to the pipeline.
- Serves mfc0 reads, mtc0 writes and eret (EXL clear).

Parameters:
- PRID_VAL, 32'h0000_2021, read-only value of PRId (reg 15).
- EXC_ENTRY, 32'h0000_4180, handler address driven on ExcEntry (constant output, reported for convenience).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- A1  in  5  mfc0 read register number (rd field).
- A2  in  5  mtc0 write register number.
- DIn  in  32  mtc0 write data.
- WE  in  1  mtc0 write enable (M-stage mtc0).
- PC  in  32  PC of the M-stage instruction (word aligned).
- BDIn  in  1  M-stage instruction is in a branch delay slot.
- ExcGotIn  in  1  exception flagged by an earlier stage for the M-stage instruction.
- ExcCodeIn  in  5  its ExcCode (AdEL=4, AdES=5, RI=10, Ov=12, ...).
- HWInt  in  6  external interrupt lines, level-sensitive.
- EXLClr  in  1  eret in M stage.
- Req  out  1  combinational: take exception/interrupt this cycle (flush, redirect to EXC_ENTRY).
- ExcEntry  out  32  EXC_ENTRY.
- EPCOut  out  32  current EPC register (eret target).
- DOut  out  32  combinational read data for A1.

Behaviour:
- Register fields:
  - SR(12): IM=[15:10], EXL=[1], IE=[0]; other bits read 0.
  - Cause(13): BD=[31], IP=[15:10], ExcCode=[6:2]; other bits read 0.
  - EPC(14): full 32 bits, [1:0] forced 0.
  - PRId(15): PRID_VAL.
  - Any other A1 value reads 32'h0.
- Reset (reset=1 at clk edge): SR=0, Cause=0, EPC=0. After reset, Req=0 and DOut=0 for any A1 other than 15.
- IntReq = |(HWInt & SR.IM) & SR.IE & ~SR.EXL. ExcReq = ExcGotIn & ~SR.EXL. Req = IntReq | ExcReq.
- Interrupt has priority over a simultaneous exception. Cause.ExcCode latched 0 for an interrupt, ExcCodeIn otherwise.
- On a clock edge with Req=1:
  - SR.EXL<=1.
  - Cause.BD<=BDIn.
  - EPC <= BDIn ? PC-4 : PC, computed modulo 2^32.
  - Cause.ExcCode latched as above.
  - Any WE or EXLClr in the same cycle is ignored.
- Cause.IP <= HWInt every non-reset cycle, independent of Req/EXL.
- WE=1, Req=0:
  - A2=12 writes IM/EXL/IE from DIn.
  - A2=14 writes DIn with [1:0] cleared.
  - A2=13/15/other: no effect (Cause is not software-writable).
- EXLClr=1, Req=0: SR.EXL<=0. If WE writes SR in the same cycle, EXLClr wins for the EXL bit only.
- Reads are combinational from current state; no write-through. An mtc0 in M is visible to a read in the next cycle.
- While EXL=1, Req stays 0 for all causes; further ExcGotIn is dropped, not queued.
- Reset asserted in the same cycle as Req: reset wins; nothing latched.

Decomposition:
- Shared package/settings header holds:
  - register numbers 12–15;
  - bit-position ranges (IM, EXL, IE, BD, IP, ExcCode);
  - ExcCode constants (Int=0, AdEL=4, AdES=5, RI=10, Ov=12), the same constants the E-stage checker uses.
- No sub-module is natural. A single flat module with one always block for state and continuous assigns for Req/DOut.

Test Plan:
- Reset then read: A1=12,13,14 -> DOut=0; A1=15 -> DOut=PRID_VAL; Req=0.
- Overflow exception: ExcGotIn=1, ExcCodeIn=12, PC=32'h3008, BDIn=0 -> Req=1 same cycle; next cycle EPC=32'h3008, Cause[6:2]=12, SR.EXL=1. Repeat with BDIn=1 -> EPC=32'h3004, Cause[31]=1.
- Interrupt priority: mtc0 SR=32'h0000_0401 (IM[0]=1, IE=1), then HWInt=6'b000001 with ExcGotIn=1, ExcCodeIn=4 in the same cycle -> Req=1, Cause.ExcCode=0, Cause.IP=6'b000001.
- EXL masking: with EXL=1, raise HWInt and ExcGotIn -> Req=0, EPC unchanged. Then EXLClr=1 -> EXL=0; next cycle, with the interrupt still pending, Req=1.
- mtc0/Req collision: WE=1, A2=14, DIn=32'hFFFF_FFFF while ExcGotIn=1, PC=32'h3000 -> EPC=32'h3000, write discarded. Separately, WE=1, A2=14, DIn=32'h1237 with no Req -> EPC=32'h1234.
- Simultaneous EXLClr and WE to SR with DIn[1]=1 -> EXL=0; IM and IE taken from DIn.

Source files
------------

// File: rtl/cp0_pkg.sv
// cp0_pkg: shared CP0 definitions for the M-stage coprocessor-0 block and
// the E-stage exception checker. It holds the register numbers, the bit
// positions of the SR/Cause fields, the ExcCode values, and the EPC helper.
package cp0_pkg;

  // CP0 register numbers (rd field of mfc0/mtc0)
  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  // SR fields
  localparam int IM_HI   = 15;
  localparam int IM_LO   = 10;
  localparam int EXL_BIT = 1;
  localparam int IE_BIT  = 0;

  // Cause fields
  localparam int BD_BIT = 31;
  localparam int IP_HI  = 15;
  localparam int IP_LO  = 10;
  localparam int EC_HI  = 6;
  localparam int EC_LO  = 2;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;

  // Restart address: a delay-slot instruction restarts at its branch.
  // The subtraction wraps modulo 2^32. The low bits are forced clear.
  function automatic logic [31:0] epc_of(input logic [31:0] pc, input logic bd);
    logic [31:0] v;
    v = bd ? (pc - 32'd4) : pc;
    return {v[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/cp0_if.sv
// cp0_if: pipeline-facing bundle of the CP0 block.
//   mfc0 read  : A1 -> DOut
//   mtc0 write : A2, DIn, WE
//   exception  : PC, BDIn, ExcGotIn, ExcCodeIn, HWInt, EXLClr
//   results    : Req (flush/redirect), ExcEntry, EPCOut
// The pipeline uses the master modport. The cp0 block uses the slave modport.
interface cp0_if;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] DIn;
  logic        WE;
  logic [31:0] PC;
  logic        BDIn;
  logic        ExcGotIn;
  logic [4:0]  ExcCodeIn;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic        Req;
  logic [31:0] ExcEntry;
  logic [31:0] EPCOut;
  logic [31:0] DOut;

  modport slave (
    input  A1, A2, DIn, WE, PC, BDIn, ExcGotIn, ExcCodeIn, HWInt, EXLClr,
    output Req, ExcEntry, EPCOut, DOut
  );

  modport master (
    output A1, A2, DIn, WE, PC, BDIn, ExcGotIn, ExcCodeIn, HWInt, EXLClr,
    input  Req, ExcEntry, EPCOut, DOut
  );
endinterface

// File: rtl/cp0.sv
// cp0: coprocessor-0 register block located in the M stage.
// It holds SR/Cause/EPC/PRId and arbitrates between interrupts and exceptions.
// It raises Req, a combinational single-cycle flush/redirect to ExcEntry.
// It also serves mfc0 reads, mtc0 writes and eret (EXL clear).
// Ports:
//   clk   - system clock, rising edge
//   reset - synchronous, active-high
//   bus   - cp0_if.slave (see cp0_if for the signal list)
module cp0
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID_VAL  = 32'h0000_2021,
  parameter logic [31:0] EXC_ENTRY = 32'h0000_4180
) (
  input  logic clk,
  input  logic reset,
  cp0_if.slave bus
);

  logic [5:0]  im_q, ip_q;
  logic        exl_q, ie_q, bd_q;
  logic [4:0]  ec_q;
  logic [31:0] epc_q;
  logic        int_req, exc_req, req;
  logic [31:0] dout;

  // While EXL is set, every cause is masked. Exceptions that arrive then are dropped.
  assign int_req = (|(bus.HWInt & im_q)) & ie_q & ~exl_q;
  assign exc_req = bus.ExcGotIn & ~exl_q;
  assign req     = int_req | exc_req;

  assign bus.Req      = req;
  assign bus.ExcEntry = EXC_ENTRY;
  assign bus.EPCOut   = epc_q;
  assign bus.DOut     = dout;

  always_comb begin
    dout = '0;
    case (bus.A1)
      REG_SR: begin
        dout[IM_HI:IM_LO] = im_q;
        dout[EXL_BIT]     = exl_q;
        dout[IE_BIT]      = ie_q;
      end
      REG_CAUSE: begin
        dout[BD_BIT]      = bd_q;
        dout[IP_HI:IP_LO] = ip_q;
        dout[EC_HI:EC_LO] = ec_q;
      end
      REG_EPC:  dout = epc_q;
      REG_PRID: dout = PRID_VAL;
      default:  dout = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      im_q  <= '0;
      exl_q <= 1'b0;
      ie_q  <= 1'b0;
      bd_q  <= 1'b0;
      ip_q  <= '0;
      ec_q  <= '0;
      epc_q <= '0;
    end else begin
      ip_q <= bus.HWInt;
      if (req) begin
        // Taking the trap overrides any mtc0/eret in the same cycle.
        // An interrupt wins over a simultaneous exception.
        exl_q <= 1'b1;
        bd_q  <= bus.BDIn;
        epc_q <= epc_of(bus.PC, bus.BDIn);
        ec_q  <= int_req ? 5'(EXC_INT) : bus.ExcCodeIn;
      end else begin
        if (bus.WE && bus.A2 == REG_SR) begin
          im_q  <= bus.DIn[IM_HI:IM_LO];
          exl_q <= bus.DIn[EXL_BIT];
          ie_q  <= bus.DIn[IE_BIT];
        end
        if (bus.WE && bus.A2 == REG_EPC)
          epc_q <= {bus.DIn[31:2], 2'b00};
        // eret wins over a same-cycle SR write, but only for the EXL bit.
        if (bus.EXLClr)
          exl_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cp0.sv
module tb_cp0;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [31:0] v;

  cp0_if bus ();
  cp0 dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.A1 = 5'd0; bus.A2 = 5'd0; bus.DIn = '0; bus.WE = 1'b0;
    bus.PC = '0; bus.BDIn = 1'b0; bus.ExcGotIn = 1'b0; bus.ExcCodeIn = '0;
    bus.HWInt = '0; bus.EXLClr = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    bus.A1 = a;
    #1;
    d = bus.DOut;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    #1;
    n_cmp++; if (bus.Req !== 1'b0) begin n_err++; $display("FAIL rst_req got %0b exp 0", bus.Req); end
    n_cmp++; if (bus.ExcEntry !== 32'h4180) begin n_err++; $display("FAIL exc_entry got %h exp 00004180", bus.ExcEntry); end
    rd(5'd12, v); n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL rst_sr got %h exp 0", v); end
    rd(5'd13, v); n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL rst_cause got %h exp 0", v); end
    rd(5'd14, v); n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL rst_epc got %h exp 0", v); end
    rd(5'd15, v); n_cmp++; if (v !== 32'h0000_2021) begin n_err++; $display("FAIL rst_prid got %h exp 00002021", v); end
    rd(5'd3, v);  n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL rd_other got %h exp 0", v); end
  endtask

  task automatic test_exception();
    // Ov, not in a delay slot
    bus.ExcGotIn = 1'b1; bus.ExcCodeIn = 5'd12; bus.PC = 32'h3008; bus.BDIn = 1'b0;
    #1;
    n_cmp++; if (bus.Req !== 1'b1) begin n_err++; $display("FAIL ov_req got %0b exp 1", bus.Req); end
    tick(); idle();
    #1;
    n_cmp++; if (bus.EPCOut !== 32'h3008) begin n_err++; $display("FAIL ov_epc got %h exp 00003008", bus.EPCOut); end
    rd(5'd13, v); n_cmp++; if (v !== 32'h0000_0030) begin n_err++; $display("FAIL ov_cause got %h exp 00000030", v); end
    rd(5'd12, v); n_cmp++; if (v !== 32'h0000_0002) begin n_err++; $display("FAIL ov_sr got %h exp 00000002", v); end
    bus.EXLClr = 1'b1; tick(); bus.EXLClr = 1'b0;
    rd(5'd12, v); n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL eret_sr got %h exp 0", v); end
    // Same exception in a delay slot
    bus.ExcGotIn = 1'b1; bus.ExcCodeIn = 5'd12; bus.PC = 32'h3008; bus.BDIn = 1'b1;
    tick(); idle();
    #1;
    n_cmp++; if (bus.EPCOut !== 32'h3004) begin n_err++; $display("FAIL bd_epc got %h exp 00003004", bus.EPCOut); end
    rd(5'd13, v); n_cmp++; if (v !== 32'h8000_0030) begin n_err++; $display("FAIL bd_cause got %h exp 80000030", v); end
    bus.EXLClr = 1'b1; tick(); bus.EXLClr = 1'b0;
  endtask

  task automatic test_int_priority();
    bus.WE = 1'b1; bus.A2 = 5'd12; bus.DIn = 32'h0000_0401;
    tick(); idle();
    rd(5'd12, v); n_cmp++; if (v !== 32'h0000_0401) begin n_err++; $display("FAIL mtc0_sr got %h exp 00000401", v); end
    bus.HWInt = 6'b000001; bus.ExcGotIn = 1'b1; bus.ExcCodeIn = 5'd4; bus.PC = 32'h2000;
    #1;
    n_cmp++; if (bus.Req !== 1'b1) begin n_err++; $display("FAIL int_req got %0b exp 1", bus.Req); end
    tick();
    bus.ExcGotIn = 1'b0;
    rd(5'd13, v); n_cmp++; if (v !== 32'h0000_0400) begin n_err++; $display("FAIL int_cause got %h exp 00000400", v); end
    n_cmp++; if (bus.EPCOut !== 32'h2000) begin n_err++; $display("FAIL int_epc got %h exp 00002000", bus.EPCOut); end
    rd(5'd12, v); n_cmp++; if (v !== 32'h0000_0403) begin n_err++; $display("FAIL int_sr got %h exp 00000403", v); end
  endtask

  task automatic test_exl_mask();
    // EXL=1 and HWInt is still high. Also raise an exception.
    bus.ExcGotIn = 1'b1; bus.ExcCodeIn = 5'd10; bus.PC = 32'h5000;
    #1;
    n_cmp++; if (bus.Req !== 1'b0) begin n_err++; $display("FAIL exl_req got %0b exp 0", bus.Req); end
    tick();
    bus.ExcGotIn = 1'b0;
    #1;
    n_cmp++; if (bus.EPCOut !== 32'h2000) begin n_err++; $display("FAIL exl_epc got %h exp 00002000", bus.EPCOut); end
    rd(5'd13, v); n_cmp++; if (v !== 32'h0000_0400) begin n_err++; $display("FAIL exl_cause got %h exp 00000400", v); end
    bus.EXLClr = 1'b1;
    tick();
    bus.EXLClr = 1'b0;
    #1;
    n_cmp++; if (bus.Req !== 1'b1) begin n_err++; $display("FAIL pend_req got %0b exp 1", bus.Req); end
    rd(5'd12, v); n_cmp++; if (v !== 32'h0000_0401) begin n_err++; $display("FAIL pend_sr got %h exp 00000401", v); end
    bus.HWInt = 6'b0;
    #1;
    n_cmp++; if (bus.Req !== 1'b0) begin n_err++; $display("FAIL drop_req got %0b exp 0", bus.Req); end
    tick();
  endtask

  task automatic test_collision();
    bus.WE = 1'b1; bus.A2 = 5'd12; bus.DIn = 32'h0;
    tick();
    bus.A2 = 5'd14; bus.DIn = 32'hFFFF_FFFF;
    bus.ExcGotIn = 1'b1; bus.ExcCodeIn = 5'd10; bus.PC = 32'h3000;
    tick(); idle();
    #1;
    n_cmp++; if (bus.EPCOut !== 32'h3000) begin n_err++; $display("FAIL coll_epc got %h exp 00003000", bus.EPCOut); end
    rd(5'd13, v); n_cmp++; if (v !== 32'h0000_0028) begin n_err++; $display("FAIL coll_cause got %h exp 00000028", v); end
    bus.EXLClr = 1'b1; tick(); bus.EXLClr = 1'b0;
    bus.WE = 1'b1; bus.A2 = 5'd14; bus.DIn = 32'h1237;
    tick(); idle();
    #1;
    n_cmp++; if (bus.EPCOut !== 32'h1234) begin n_err++; $display("FAIL mtc0_epc got %h exp 00001234", bus.EPCOut); end
    bus.WE = 1'b1; bus.A2 = 5'd13; bus.DIn = 32'hFFFF_FFFF;
    tick();
    bus.A2 = 5'd15;
    tick(); idle();
    rd(5'd13, v); n_cmp++; if (v !== 32'h0000_0028) begin n_err++; $display("FAIL cause_ro got %h exp 00000028", v); end
    rd(5'd15, v); n_cmp++; if (v !== 32'h0000_2021) begin n_err++; $display("FAIL prid_ro got %h exp 00002021", v); end
  endtask

  task automatic test_exlclr_we();
    bus.WE = 1'b1; bus.A2 = 5'd12; bus.DIn = 32'hFFFF_FFFF; bus.EXLClr = 1'b1;
    tick(); idle();
    rd(5'd12, v); n_cmp++; if (v !== 32'h0000_FC01) begin n_err++; $display("FAIL clr_we_sr got %h exp 0000fc01", v); end
    bus.HWInt = 6'b100000;
    #1;
    n_cmp++; if (bus.Req !== 1'b1) begin n_err++; $display("FAIL im5_req got %0b exp 1", bus.Req); end
    bus.HWInt = 6'b0;
    #1;
  endtask

  task automatic test_wrap_and_reset();
    // EPC wraps when PC=0 is in a delay slot
    bus.ExcGotIn = 1'b1; bus.ExcCodeIn = 5'd5; bus.PC = 32'h0; bus.BDIn = 1'b1;
    tick(); idle();
    #1;
    n_cmp++; if (bus.EPCOut !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_epc got %h exp fffffffc", bus.EPCOut); end
    rd(5'd13, v); n_cmp++; if (v !== 32'h8000_0014) begin n_err++; $display("FAIL wrap_cause got %h exp 80000014", v); end
    bus.EXLClr = 1'b1; tick(); bus.EXLClr = 1'b0;
    // Reset overrides a concurrent trap
    bus.ExcGotIn = 1'b1; bus.ExcCodeIn = 5'd12; bus.PC = 32'h7000; bus.HWInt = 6'b000001;
    reset = 1'b1;
    tick();
    reset = 1'b0; idle();
    #1;
    n_cmp++; if (bus.EPCOut !== 32'h0) begin n_err++; $display("FAIL rw_epc got %h exp 0", bus.EPCOut); end
    rd(5'd13, v); n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL rw_cause got %h exp 0", v); end
    rd(5'd12, v); n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL rw_sr got %h exp 0", v); end
  endtask

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_exception();
    test_int_priority();
    test_exl_mask();
    test_collision();
    test_exlclr_we();
    test_wrap_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
